// File: rtl/mips.sv
// Five-stage MIPS subset pipeline (IF/ID/EX/MEM/WB) with forwarding, load-use stall,
// EX-resolved branches/jr and ID-resolved j/jal.

// Fetch program counter register.
module mips_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  output logic [31:0] PC_o
);
  // PC update, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) PC_o <= 32'h0;
    else     PC_o <= pc_next;
  end
endmodule

// Instruction ROM, combinational read; untouched by reset.
module mips_imem (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [9:0]  addr,
  output logic [31:0] data
);
  logic [31:0] instructionMemory [0:1023];

  // Optional load port; tied off in the core, contents normally preloaded.
  always_ff @(posedge clk) begin
    if (we) instructionMemory[waddr] <= wdata;
  end

  assign data = instructionMemory[addr];
endmodule

module mips (
  input logic clk,
  input logic rst
);
  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluPassB} alu_op_e;

  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    alu_op_e     op;
    logic        use_imm;
    logic [31:0] imm;
    logic        mem_read;
    logic        mem_write;
    logic        beq;
    logic        bne;
    logic        jr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc4;
  } id_ex_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] store;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] data;
  } mem_wb_t;

  logic [31:0] PC_o, pc_next, pc4, Instruction;
  logic [31:0] if_id_instr, if_id_pc4;
  id_ex_t      id_ex, id_ctrl;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic [31:0] rf   [0:31];
  logic [31:0] dmem [0:1023];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        id_jump, stall, ex_redirect, br_taken;
  logic [31:0] jump_target, ex_target, fwd_a, fwd_b, alu_b, alu_y, load_data;

  mips_pc m_PC (.clk(clk), .rst(rst), .pc_next(pc_next), .PC_o(PC_o));

  mips_imem m_InstructionMemory (
    .clk(clk), .we(1'b0), .waddr(10'h0), .wdata(32'h0),
    .addr(PC_o[11:2]), .data(Instruction)
  );

  assign pc4         = PC_o + 32'd4;
  assign opcode      = if_id_instr[31:26];
  assign rs          = if_id_instr[25:21];
  assign rt          = if_id_instr[20:16];
  assign rd          = if_id_instr[15:11];
  assign funct       = if_id_instr[5:0];
  assign imm16       = if_id_instr[15:0];
  assign jump_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

  // Decode plus register read; WB bypass models the first-half-cycle register write.
  always_comb begin
    id_ctrl         = '0;
    id_jump         = 1'b0;
    id_ctrl.dst     = rd;
    id_ctrl.imm     = {{16{imm16[15]}}, imm16};
    id_ctrl.rs      = rs;
    id_ctrl.rt      = rt;
    id_ctrl.shamt   = if_id_instr[10:6];
    id_ctrl.pc4     = if_id_pc4;
    id_ctrl.a       = (rs == 5'd0) ? 32'h0 :
                      (mem_wb.we && mem_wb.dst == rs) ? mem_wb.data : rf[rs];
    id_ctrl.b       = (rt == 5'd0) ? 32'h0 :
                      (mem_wb.we && mem_wb.dst == rt) ? mem_wb.data : rf[rt];
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21: begin id_ctrl.we = 1'b1; id_ctrl.op = AluAdd; end
          6'h23: begin id_ctrl.we = 1'b1; id_ctrl.op = AluSub; end
          6'h24: begin id_ctrl.we = 1'b1; id_ctrl.op = AluAnd; end
          6'h25: begin id_ctrl.we = 1'b1; id_ctrl.op = AluOr;  end
          6'h2a: begin id_ctrl.we = 1'b1; id_ctrl.op = AluSlt; end
          6'h00: begin id_ctrl.we = 1'b1; id_ctrl.op = AluSll; end
          6'h08: id_ctrl.jr = 1'b1;
          default: ;
        endcase
      end
      6'h09: begin id_ctrl.we = 1'b1; id_ctrl.dst = rt; id_ctrl.use_imm = 1'b1; end
      6'h0c: begin
        id_ctrl.we = 1'b1; id_ctrl.dst = rt; id_ctrl.use_imm = 1'b1;
        id_ctrl.op = AluAnd; id_ctrl.imm = {16'h0, imm16};
      end
      6'h0d: begin
        id_ctrl.we = 1'b1; id_ctrl.dst = rt; id_ctrl.use_imm = 1'b1;
        id_ctrl.op = AluOr; id_ctrl.imm = {16'h0, imm16};
      end
      6'h0f: begin
        id_ctrl.we = 1'b1; id_ctrl.dst = rt; id_ctrl.use_imm = 1'b1;
        id_ctrl.op = AluPassB; id_ctrl.imm = {imm16, 16'h0};
      end
      6'h23: begin
        id_ctrl.we = 1'b1; id_ctrl.dst = rt; id_ctrl.use_imm = 1'b1;
        id_ctrl.mem_read = 1'b1;
      end
      6'h2b: begin id_ctrl.use_imm = 1'b1; id_ctrl.mem_write = 1'b1; end
      6'h04: id_ctrl.beq = 1'b1;
      6'h05: id_ctrl.bne = 1'b1;
      6'h02: id_jump = 1'b1;
      // jal carries its link address through the ALU as an immediate.
      6'h03: begin
        id_jump = 1'b1; id_ctrl.we = 1'b1; id_ctrl.dst = 5'd31;
        id_ctrl.use_imm = 1'b1; id_ctrl.op = AluPassB; id_ctrl.imm = if_id_pc4;
      end
      default: ;
    endcase
  end

  // Operand forwarding, ALU and EX-stage redirect resolution.
  always_comb begin
    fwd_a = id_ex.a;
    if (ex_mem.we && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rs)      fwd_a = ex_mem.alu;
    else if (mem_wb.we && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rs) fwd_a = mem_wb.data;
    fwd_b = id_ex.b;
    if (ex_mem.we && ex_mem.dst != 5'd0 && ex_mem.dst == id_ex.rt)      fwd_b = ex_mem.alu;
    else if (mem_wb.we && mem_wb.dst != 5'd0 && mem_wb.dst == id_ex.rt) fwd_b = mem_wb.data;
    alu_b = id_ex.use_imm ? id_ex.imm : fwd_b;
    case (id_ex.op)
      AluSub:   alu_y = fwd_a - alu_b;
      AluAnd:   alu_y = fwd_a & alu_b;
      AluOr:    alu_y = fwd_a | alu_b;
      AluSlt:   alu_y = {31'h0, $signed(fwd_a) < $signed(alu_b)};
      AluSll:   alu_y = fwd_b << id_ex.shamt;
      AluPassB: alu_y = alu_b;
      default:  alu_y = fwd_a + alu_b;
    endcase
    br_taken    = (id_ex.beq && fwd_a == fwd_b) || (id_ex.bne && fwd_a != fwd_b);
    ex_redirect = br_taken || id_ex.jr;
    ex_target   = id_ex.jr ? fwd_a : id_ex.pc4 + {id_ex.imm[29:0], 2'b00};
    // An EX redirect squashes the dependent instruction, so the stall is moot.
    stall       = id_ex.mem_read && (id_ex.rt == rs || id_ex.rt == rt) && !ex_redirect;
  end

  // Next fetch address: EX redirect beats stall, stall beats ID jump.
  always_comb begin
    if (ex_redirect)  pc_next = ex_target;
    else if (stall)   pc_next = PC_o;
    else if (id_jump) pc_next = jump_target;
    else              pc_next = pc4;
  end

  assign load_data = dmem[ex_mem.alu[11:2]];

  // IF/ID and ID/EX registers with flush and bubble insertion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr <= 32'h0;
      if_id_pc4   <= 32'h0;
      id_ex       <= '0;
    end else begin
      if (ex_redirect || (!stall && id_jump)) begin
        if_id_instr <= 32'h0;
        if_id_pc4   <= 32'h0;
      end else if (!stall) begin
        if_id_instr <= Instruction;
        if_id_pc4   <= pc4;
      end
      id_ex <= (ex_redirect || stall) ? '0 : id_ctrl;
    end
  end

  // EX/MEM and MEM/WB registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      ex_mem.we        <= id_ex.we;
      ex_mem.dst       <= id_ex.dst;
      ex_mem.alu       <= alu_y;
      ex_mem.store     <= fwd_b;
      ex_mem.mem_read  <= id_ex.mem_read;
      ex_mem.mem_write <= id_ex.mem_write;
      mem_wb.we        <= ex_mem.we;
      mem_wb.dst       <= ex_mem.dst;
      mem_wb.data      <= ex_mem.mem_read ? load_data : ex_mem.alu;
    end
  end

  // Data memory store port; whole array cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= 32'h0;
    end else if (ex_mem.mem_write) begin
      dmem[ex_mem.alu[11:2]] <= ex_mem.store;
    end
  end

  // Register file write port; $0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (mem_wb.we && mem_wb.dst != 5'd0) begin
      rf[mem_wb.dst] <= mem_wb.data;
    end
  end
endmodule

// File: tb/tb_mips.sv
// Directed bench for the mips pipeline: programs are poked into instruction memory,
// architectural state is read through hierarchy after a fixed number of cycles.
module tb_mips;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] prog [0:31];

  mips dut (.clk(clk), .rst(rst));

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) begin
      prog[i] = 32'h0;
      dut.m_InstructionMemory.instructionMemory[i] = 32'h0;
    end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    prog[idx] = w;
    dut.m_InstructionMemory.instructionMemory[idx] = w;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;

    // Forwarding program, plus the reset/fetch sequence.
    #5 rst = 1'b1;
    #1 check("pc_in_reset", dut.m_PC.PC_o, 32'h0);
    clear_prog();
    put(0, 32'h34010005);  // ori  $1,$0,5
    put(1, 32'h00211021);  // addu $2,$1,$1
    put(2, 32'h00411823);  // subu $3,$2,$1
    @(negedge clk);
    check("pc_reset_held", dut.m_PC.PC_o, 32'h0);
    check("instr_at_0", dut.Instruction, prog[0]);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("pc_seq", dut.m_PC.PC_o, 32'(4 * k));
      check("instr_seq", dut.Instruction, prog[k]);
    end
    step(5);
    check("fwd_no_stall_pc", dut.m_PC.PC_o, 32'd32);
    check("fwd_r2", dut.rf[2], 32'd10);
    check("fwd_r3", dut.rf[3], 32'd5);

    // Store/load round trip with a single load-use stall.
    rst = 1'b1;
    clear_prog();
    put(0, 32'h3C011234);  // lui  $1,0x1234
    put(1, 32'h34215678);  // ori  $1,$1,0x5678
    put(2, 32'hAC010004);  // sw   $1,4($0)
    put(3, 32'h8C040004);  // lw   $4,4($0)
    put(4, 32'h00842821);  // addu $5,$4,$4
    @(negedge clk);
    rst = 1'b0;
    step(10);
    check("lu_one_stall_pc", dut.m_PC.PC_o, 32'd36);
    check("lu_dmem1", dut.dmem[1], 32'h12345678);
    check("lu_r4", dut.rf[4], 32'h12345678);
    check("lu_r5", dut.rf[5], 32'h2468ACF0);

    // Mid-run reset clears state immediately but keeps instruction memory.
    @(posedge clk);
    #10 rst = 1'b1;
    #1;
    check("midrst_pc", dut.m_PC.PC_o, 32'h0);
    check("midrst_r5", dut.rf[5], 32'h0);
    check("midrst_dmem1", dut.dmem[1], 32'h0);
    check("midrst_imem_kept", dut.Instruction, 32'h3C011234);

    // Taken beq flushes the two younger instructions.
    clear_prog();
    put(0, 32'h34010001);  // ori $1,$0,1
    put(1, 32'h10210002);  // beq $1,$1,+2
    put(2, 32'h34060007);  // ori $6,$0,7
    put(3, 32'h34070008);  // ori $7,$0,8
    put(4, 32'h34080009);  // ori $8,$0,9
    @(negedge clk);
    rst = 1'b0;
    step(12);
    check("br_r6", dut.rf[6], 32'h0);
    check("br_r7", dut.rf[7], 32'h0);
    check("br_r8", dut.rf[8], 32'd9);

    // jal / jr round trip; the slots after each redirect must not execute.
    rst = 1'b1;
    clear_prog();
    put(0, 32'h0C000010);   // jal  0x40
    put(1, 32'h254A0001);   // addiu $10,$10,1
    put(2, 32'h08000002);   // j    0x8 (spin)
    put(16, 32'h03E00008);  // jr   $31
    put(17, 32'h256B0001);  // addiu $11,$11,1
    @(negedge clk);
    rst = 1'b0;
    step(20);
    check("jal_r31", dut.rf[31], 32'd4);
    check("jal_resume_once", dut.rf[10], 32'd1);
    check("jr_flush_r11", dut.rf[11], 32'h0);

    // $0 protection, slt, sll, andi.
    rst = 1'b1;
    clear_prog();
    put(0, 32'h24000005);  // addiu $0,$0,5
    put(1, 32'h00004821);  // addu  $9,$0,$0
    put(2, 32'h240CFFFF);  // addiu $12,$0,-1
    put(3, 32'h0180682A);  // slt   $13,$12,$0
    put(4, 32'h000C7100);  // sll   $14,$12,4
    put(5, 32'h318FF0F0);  // andi  $15,$12,0xF0F0
    @(negedge clk);
    rst = 1'b0;
    step(12);
    check("zero_r9", dut.rf[9], 32'h0);
    check("zero_r0", dut.rf[0], 32'h0);
    check("addiu_sext_r12", dut.rf[12], 32'hFFFFFFFF);
    check("slt_signed_r13", dut.rf[13], 32'd1);
    check("sll_r14", dut.rf[14], 32'hFFFFFFF0);
    check("andi_zext_r15", dut.rf[15], 32'h0000F0F0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips.md
MIPS -- requirements
Module: mips

Interface
REQ-001 The block SHALL have no parameters; all sizes are fixed as stated below.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have no other ports; state is observed through hierarchy only.
REQ-005 Observable nets SHALL be:
  - instance m_PC with 32-bit output PC_o (current fetch PC);
  - top-level 32-bit net Instruction (instruction fetched at PC_o);
  - instance m_InstructionMemory containing array instructionMemory[0:1023] of 32-bit words, loadable by hex memory-file load.

Function
REQ-006 The pipeline SHALL have five stages: IF, ID, EX, MEM, WB, separated by IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-007 Supported instructions SHALL be addu, subu, and, or, slt, sll, addiu, andi, ori, lui, lw, sw, beq, bne, j, jal, jr.
REQ-008 Any other encoding SHALL execute as a nop: no register or memory write.
REQ-009 Instruction memory: word-addressed by PC[11:2]; read is combinational.
REQ-010 Data memory: 1024 x 32 words addressed by ALUresult[11:2]; read is combinational; write is synchronous on a sw in MEM.
REQ-011 Unaligned data addresses SHALL ignore bits [1:0].
REQ-012 Register file: 32 x 32; $0 always reads 0 and ignores writes.
REQ-013 Register-file writes SHALL occur in the first half of the cycle, so an ID read in the same cycle as a WB write of that register returns the new value.
REQ-014 Arithmetic SHALL be 32-bit two's complement with wrap-around and no overflow trap.
REQ-015 Extension rules:
  - addiu, lw, sw: sign-extend the immediate;
  - andi, ori: zero-extend;
  - lui: places imm16 in bits [31:16], zeros below;
  - slt: signed compare, result 1 or 0.
REQ-016 Without hazards, PC SHALL increment by 4 each cycle and one instruction SHALL complete per cycle.
REQ-017 Forwarding SHALL supply EX operands from EX/MEM (priority) or MEM/WB when the destination register matches a source register and the destination is nonzero.
REQ-018 Load-use hazard: when the instruction in EX is lw and its rt matches rs/rt of the instruction in ID:
  - hold PC and IF/ID for one cycle;
  - insert a bubble into ID/EX.
REQ-019 beq/bne SHALL resolve in EX.
  - If taken: PC <= PC_of_branch + 4 + (sext(imm16) << 2), and IF/ID and ID/EX are flushed (2-cycle penalty).
  - Not taken: no penalty.
REQ-020 j and jal SHALL redirect in ID: target = {PC+4[31:28], imm26, 2'b00}; IF/ID is flushed (1-cycle penalty).
REQ-021 jal SHALL write PC_of_jal + 4 to $31 through the normal WB path.
REQ-022 jr SHALL redirect in EX to forwarded rs, with the same flush as a taken branch.
REQ-023 No branch delay slot: flushed instructions SHALL produce no side effects.
REQ-024 If a stall and an EX redirect occur in the same cycle, the redirect SHALL win and the stall SHALL be cancelled.

Reset
REQ-025 While rst=1, regardless of clk:
  - PC_o = 0x00000000;
  - all pipeline registers hold nop (0x00000000) with all control signals deasserted;
  - all 32 GPRs = 0.
REQ-026 Data memory SHALL be cleared to 0 on reset.
REQ-027 Instruction memory SHALL NOT be altered by reset.
REQ-028 Assertion of rst mid-operation SHALL discard all in-flight instructions immediately.
REQ-029 After rst deasserts, the first rising edge SHALL fetch the next instruction (PC_o -> 0x00000004).

Verification
REQ-030 Reset pulse during run: assert rst at t=5 ns, release, run with a 100 ns clock period -> PC_o = 0 during reset, then 0, 4, 8 … per edge, with Instruction = instructionMemory[PC_o>>2].
REQ-031 Back-to-back ALU forwarding: program ori $1,$0,5; addu $2,$1,$1; subu $3,$2,$1 -> $2=10, $3=5, no stall cycles.
REQ-032 Memory round trip with load-use: lui $1,0x1234; ori $1,$1,0x5678; sw $1,4($0); lw $4,4($0); addu $5,$4,$4 -> dmem[1]=0x12345678, $5=0x2468ACF0, exactly one stall cycle.
REQ-033 Branch flush: ori $1,$0,1; beq $1,$1,+2; ori $6,$0,7; ori $7,$0,8; ori $8,$0,9 -> $6=0, $7=0, $8=9.
REQ-034 Jump and link: jal to word 0x10 at PC 0x0; jr $31 placed at 0x40 -> $31=4, execution resumes at 0x4, and the instruction fetched after the jal is flushed.
REQ-035 $0 protection: addiu $0,$0,5 then addu $9,$0,$0 -> $9=0.
